// File: rtl/agc_loop_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : agc_loop_ctrl
// Brief   : Closed-loop AGC controller. Gathers per-window abs/gt/lt
//           statistics and drives scale/offset updates into the AGC DSP.
// Revision: 1.0 - initial release
// ============================================================================
module agc_loop_ctrl #(
  parameter int WINDOW_LOG2    = 10,
  parameter int ABS_BITS       = 4,
  parameter int TARGET_ABS_SUM = 3276,
  parameter int SCALE_INIT     = 4096,
  parameter int SCALE_MIN      = 256,
  parameter int SCALE_MAX      = 131071,
  parameter int SCALE_SHIFT    = 4,
  parameter int OFFSET_SHIFT   = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                en_i,
  input  logic                freeze_i,
  input  logic [ABS_BITS-1:0] abs_i,
  input  logic                gt_i,
  input  logic                lt_i,
  output logic [16:0]         scale_o,
  output logic [15:0]         offset_o,
  output logic                ce_scale_o,
  output logic                ce_offset_o,
  output logic                apply_o,
  output logic                done_o
);

  localparam int SUM_W = ABS_BITS + WINDOW_LOG2;
  localparam int CNT_W = WINDOW_LOG2 + 1;
  localparam logic signed [31:0] C_TARGET = TARGET_ABS_SUM;
  localparam logic signed [31:0] C_SMIN   = SCALE_MIN;
  localparam logic signed [31:0] C_SMAX   = SCALE_MAX;
  localparam logic [16:0]        C_SINIT  = SCALE_INIT;

  typedef enum logic [1:0] {
    ST_ACCUM   = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_LOAD    = 2'd2,
    ST_APPLY   = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [SUM_W-1:0]       abs_sum_q, abs_sum_d, snap_abs_q, snap_abs_d;
  logic [CNT_W-1:0]       gt_cnt_q, gt_cnt_d, lt_cnt_q, lt_cnt_d;
  logic [CNT_W-1:0]       snap_gt_q, snap_gt_d, snap_lt_q, snap_lt_d;
  logic [WINDOW_LOG2-1:0] win_cnt_q, win_cnt_d;
  logic [16:0]            scale_q, scale_d;
  logic [15:0]            offset_q, offset_d;
  logic                   ce_q, ce_d, apply_q, apply_d, done_q, done_d;

  logic                   w_terminal;
  logic signed [31:0]     w_err, w_s, w_d, w_o;

  assign w_terminal = en_i && (win_cnt_q == '1);

  // Statistics run independently of the FSM so no sample is ever lost.
  always_comb begin
    abs_sum_d  = abs_sum_q;
    gt_cnt_d   = gt_cnt_q;
    lt_cnt_d   = lt_cnt_q;
    win_cnt_d  = win_cnt_q;
    snap_abs_d = snap_abs_q;
    snap_gt_d  = snap_gt_q;
    snap_lt_d  = snap_lt_q;
    if (en_i) begin
      win_cnt_d = win_cnt_q + WINDOW_LOG2'(1);
      if (w_terminal) begin
        snap_abs_d = abs_sum_q + SUM_W'(abs_i);
        snap_gt_d  = gt_cnt_q + CNT_W'(gt_i);
        snap_lt_d  = lt_cnt_q + CNT_W'(lt_i);
        abs_sum_d  = '0;
        gt_cnt_d   = '0;
        lt_cnt_d   = '0;
      end else begin
        abs_sum_d = abs_sum_q + SUM_W'(abs_i);
        gt_cnt_d  = gt_cnt_q + CNT_W'(gt_i);
        lt_cnt_d  = lt_cnt_q + CNT_W'(lt_i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ACCUM:   if (w_terminal) state_d = ST_COMPUTE;
      ST_COMPUTE: state_d = ST_LOAD;
      ST_LOAD:    state_d = ST_APPLY;
      ST_APPLY:   state_d = ST_ACCUM;
      default:    state_d = ST_ACCUM;
    endcase
  end

  always_comb begin
    done_d  = w_terminal;
    ce_d    = (state_q == ST_COMPUTE) && !freeze_i;
    apply_d = ce_q;

    w_err = C_TARGET - $signed({{(32-SUM_W){1'b0}}, snap_abs_q});
    w_s   = $signed({15'd0, scale_q}) + (w_err >>> SCALE_SHIFT);
    w_d   = $signed({{(32-CNT_W){1'b0}}, snap_gt_q})
          - $signed({{(32-CNT_W){1'b0}}, snap_lt_q});
    w_o   = $signed({{16{offset_q[15]}}, offset_q}) - (w_d >>> OFFSET_SHIFT);

    scale_d  = scale_q;
    offset_d = offset_q;
    if (ce_d) begin
      if (w_s < C_SMIN)      scale_d = C_SMIN[16:0];
      else if (w_s > C_SMAX) scale_d = C_SMAX[16:0];
      else                   scale_d = 17'(w_s);

      if (w_o > 32'sd32767)       offset_d = 16'h7FFF;
      else if (w_o < -32'sd32768) offset_d = 16'h8000;
      else                        offset_d = 16'(w_o);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_ACCUM;
      abs_sum_q  <= '0;
      gt_cnt_q   <= '0;
      lt_cnt_q   <= '0;
      win_cnt_q  <= '0;
      snap_abs_q <= '0;
      snap_gt_q  <= '0;
      snap_lt_q  <= '0;
      scale_q    <= C_SINIT;
      offset_q   <= '0;
      ce_q       <= 1'b0;
      apply_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      abs_sum_q  <= abs_sum_d;
      gt_cnt_q   <= gt_cnt_d;
      lt_cnt_q   <= lt_cnt_d;
      win_cnt_q  <= win_cnt_d;
      snap_abs_q <= snap_abs_d;
      snap_gt_q  <= snap_gt_d;
      snap_lt_q  <= snap_lt_d;
      scale_q    <= scale_d;
      offset_q   <= offset_d;
      ce_q       <= ce_d;
      apply_q    <= apply_d;
      done_q     <= done_d;
    end
  end

  assign scale_o     = scale_q;
  assign offset_o    = offset_q;
  assign ce_scale_o  = ce_q;
  assign ce_offset_o = ce_q;
  assign apply_o     = apply_q;
  assign done_o      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_agc_loop_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_agc_loop_ctrl
// Brief   : Scoreboard bench for agc_loop_ctrl with a window-level reference
//           model; a second instance starts near the top scale clamp.
// Revision: 1.0 - initial release
// ============================================================================
module tb_agc_loop_ctrl;

  localparam int WIN       = 1024;
  localparam int TARGET    = 3276;
  localparam int SINIT     = 4096;
  localparam int SMIN      = 256;
  localparam int SMAX      = 131071;
  localparam int HI_INIT   = 130900;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1, en_i = 1'b0, freeze_i = 1'b0, gt_i = 1'b0, lt_i = 1'b0;
  logic [3:0]  abs_i = 4'd0;
  logic [16:0] scale_o, scale_hi_o;
  logic [15:0] offset_o, offset_hi_o;
  logic        ce_scale_o, ce_offset_o, apply_o, done_o;
  logic        ce_scale_hi_o, ce_offset_hi_o, apply_hi_o, done_hi_o;

  agc_loop_ctrl dut (
    .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .freeze_i(freeze_i),
    .abs_i(abs_i), .gt_i(gt_i), .lt_i(lt_i),
    .scale_o(scale_o), .offset_o(offset_o), .ce_scale_o(ce_scale_o),
    .ce_offset_o(ce_offset_o), .apply_o(apply_o), .done_o(done_o)
  );

  agc_loop_ctrl #(.SCALE_INIT(HI_INIT)) dut_hi (
    .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .freeze_i(freeze_i),
    .abs_i(4'd0), .gt_i(1'b0), .lt_i(1'b0),
    .scale_o(scale_hi_o), .offset_o(offset_hi_o), .ce_scale_o(ce_scale_hi_o),
    .ce_offset_o(ce_offset_hi_o), .apply_o(apply_hi_o), .done_o(done_hi_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int scale;
    int off;
    int scale_hi;
    bit frozen;
  } exp_t;

  exp_t sb_q[$];
  int   vectors = 0, fails = 0;

  // Reference model state: committed values and running window statistics.
  int m_scale, m_off, m_hi;
  int acc_abs, acc_gt, acc_lt, acc_n;
  bit pend;
  int pend_cyc, p_abs, p_gt, p_lt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] ex);
    vectors++;
    if (act !== ex) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, $signed(act), $signed(ex), cyc);
    end
  endtask

  function automatic int clamp(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  task automatic model_reset();
    m_scale = SINIT; m_off = 0; m_hi = HI_INIT;
    acc_abs = 0; acc_gt = 0; acc_lt = 0; acc_n = 0;
    pend = 0;
    sb_q.delete();
  endtask

  task automatic resolve(input bit frz);
    exp_t e;
    e.cyc      = pend_cyc + 1;
    e.frozen   = frz;
    e.scale    = clamp(m_scale + ((TARGET - p_abs) >>> 4), SMIN, SMAX);
    e.off      = clamp(m_off - ((p_gt - p_lt) >>> 2), -32768, 32767);
    e.scale_hi = clamp(m_hi + (TARGET >>> 4), SMIN, SMAX);
    sb_q.push_back(e);
    if (!frz) begin
      m_scale = e.scale; m_off = e.off; m_hi = e.scale_hi;
    end
  endtask

  task automatic drive(input bit en, input int a, input bit g, input bit l, input bit frz);
    @(posedge clk); #1;
    rst_i = 1'b0; en_i = en; abs_i = 4'(a); gt_i = g; lt_i = l; freeze_i = frz;
    if (pend) begin
      resolve(frz);
      pend = 0;
    end
    if (en) begin
      acc_abs += a; acc_gt += int'(g); acc_lt += int'(l); acc_n++;
      if (acc_n == WIN) begin
        pend = 1; pend_cyc = cyc;
        p_abs = acc_abs; p_gt = acc_gt; p_lt = acc_lt;
        acc_abs = 0; acc_gt = 0; acc_lt = 0; acc_n = 0;
      end
    end
  endtask

  task automatic window(input int a, input bit g, input bit l, input bit frz);
    repeat (WIN) drive(1'b1, a, g, l, frz);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset(input int n);
    @(posedge clk); #1;
    rst_i = 1'b1; en_i = 1'b0; freeze_i = 1'b0;
    model_reset();
    repeat (n - 1) @(posedge clk);
  endtask

  // Monitor: tracks committed values and pops one expectation per done pulse.
  exp_t cur;
  int   ph = 0;
  int   c_s = SINIT, c_o = 0, c_h = HI_INIT;

  always @(negedge clk) begin : mon
    bit exp_done, exp_ce, exp_ap;
    if (rst_i) begin
      ph = 0; c_s = SINIT; c_o = 0; c_h = HI_INIT;
    end else if (ph == 1 && !cur.frozen) begin
      c_s = cur.scale; c_o = cur.off; c_h = cur.scale_hi;
    end
    exp_ce   = !rst_i && ph == 1 && !cur.frozen;
    exp_ap   = !rst_i && ph == 2 && !cur.frozen;
    exp_done = sb_q.size() > 0 && sb_q[0].cyc == cyc;
    chk("scale", {15'd0, scale_o}, c_s);
    chk("offset", {{16{offset_o[15]}}, offset_o}, c_o);
    chk("scale_hi", {15'd0, scale_hi_o}, c_h);
    chk("offset_hi", {16'd0, offset_hi_o}, 0);
    chk("ce_scale", {31'd0, ce_scale_o}, {31'd0, exp_ce});
    chk("ce_offset", {31'd0, ce_offset_o}, {31'd0, exp_ce});
    chk("apply", {31'd0, apply_o}, {31'd0, exp_ap});
    chk("ce_hi", {31'd0, ce_scale_hi_o}, {31'd0, exp_ce});
    chk("apply_hi", {31'd0, apply_hi_o}, {31'd0, exp_ap});
    chk("done", {31'd0, done_o}, {31'd0, exp_done});
    chk("done_hi", {31'd0, done_hi_o}, {31'd0, exp_done});
    ph = (ph == 1) ? 2 : 0;
    if (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      cur = sb_q.pop_front();
      ph  = 1;
    end
  end

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    // Mid-window reset, then clean windows.
    repeat (500) drive(1'b1, int'($urandom_range(0, 15)), 1'b0, 1'b0, 1'b0);
    do_reset(2);
    window(3, 1'b0, 1'b0, 1'b0); idle(4);
    window(3, 1'b1, 1'b0, 1'b0); idle(4);
    window(3, 1'b1, 1'b1, 1'b0); idle(4);
    // Drive scale into the lower clamp, then back up.
    repeat (7) window(15, 1'b0, 1'b0, 1'b0);
    repeat (2) window(0, 1'b0, 1'b0, 1'b0);
    // Random 50% enable, random statistics and freeze.
    repeat (2 * WIN * 2 + 100)
      drive(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            $urandom_range(0, 3) == 0);
    while (acc_n != 0)
      drive(1'b1, int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'b0);
    idle(4);
    // Frozen window, then an unfrozen one.
    window(4, 1'b0, 1'b1, 1'b1);
    drive(1'b0, 0, 1'b0, 1'b0, 1'b1);
    idle(3);
    window(5, 1'b1, 1'b0, 1'b0);
    idle(4);
    // Reset landing on the LOAD cycle.
    window(2, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 0, 1'b0, 1'b0, 1'b0);
    do_reset(2);
    window(3, 1'b0, 1'b0, 1'b0);
    idle(10);
    @(negedge clk);
    chk("sb_empty", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
`default_nettype wire
